// File: rtl/x_ramb_dp_sc.sv
// x_ramb_dp_sc: single-clock true dual-port RAM with independent port widths and collision reporting
module x_ramb_dp_sc #(
    parameter int              MEM_BITS     = 16384,
    parameter int              DW_A         = 4,
    parameter int              DW_B         = 16,
    parameter int              AW_A         = 12,
    parameter int              AW_B         = 10,
    parameter int              WRITE_MODE_A = 0,
    parameter int              WRITE_MODE_B = 0,
    parameter logic [DW_A-1:0] SRVAL_A      = '0,
    parameter logic [DW_B-1:0] SRVAL_B      = '0,
    parameter int              DO_REG_A     = 0,
    parameter int              DO_REG_B     = 0
) (
    input  logic            CLK,
    input  logic            SSR,
    input  logic            ENA,
    input  logic            WEA,
    input  logic [AW_A-1:0] ADDRA,
    input  logic [DW_A-1:0] DIA,
    output logic [DW_A-1:0] DOA,
    input  logic            ENB,
    input  logic            WEB,
    input  logic [AW_B-1:0] ADDRB,
    input  logic [DW_B-1:0] DIB,
    output logic [DW_B-1:0] DOB,
    output logic            COLL
);
    localparam int BW = $clog2(MEM_BITS);
    localparam int LA = $clog2(DW_A);
    localparam int LB = $clog2(DW_B);
    localparam int LM = (LA > LB) ? LA : LB;

    generate
        if ((MEM_BITS & (MEM_BITS - 1)) != 0 || (DW_A & (DW_A - 1)) != 0 || (DW_B & (DW_B - 1)) != 0 ||
            DW_A < 1 || DW_A > 32 || DW_B < 1 || DW_B > 32 ||
            AW_A != $clog2(MEM_BITS / DW_A) || AW_B != $clog2(MEM_BITS / DW_B)) begin : g_bad_param
            $fatal(1, "x_ramb_dp_sc: illegal parameter combination");
        end
    endgenerate

    // Flat bit array: narrow word a lands at bit a*DW_N, which yields the
    // little-endian packing of narrow words inside each wide word.
    logic [MEM_BITS-1:0] r_mem = '0;
    logic [DW_A-1:0]     r_doa, r_doa2;
    logic [DW_B-1:0]     r_dob, r_dob2;
    logic                r_coll;
    logic [BW-1:0]       w_base_a, w_base_b;
    logic [DW_A-1:0]     w_rd_a;
    logic [DW_B-1:0]     w_rd_b;
    logic                w_ovl;

    assign w_base_a = BW'(ADDRA) << LA;
    assign w_base_b = BW'(ADDRB) << LB;
    assign w_rd_a   = r_mem[w_base_a +: DW_A];
    assign w_rd_b   = r_mem[w_base_b +: DW_B];
    // Aligned power-of-two ranges intersect iff they share the wider word index.
    assign w_ovl    = (w_base_a >> LM) == (w_base_b >> LM);

    // Array writes; B is applied last so it wins on overlapping bits.
    always_ff @(posedge CLK) begin
        if (!SSR) begin
            if (ENA && WEA) r_mem[w_base_a +: DW_A] <= DIA;
            if (ENB && WEB) r_mem[w_base_b +: DW_B] <= DIB;
        end
    end

    // Port A first output stage: reset value, write-mode data or read data; NO_CHANGE writes hold.
    always_ff @(posedge CLK) begin
        if (SSR) r_doa <= SRVAL_A;
        else if (ENA && (!WEA || WRITE_MODE_A != 2)) r_doa <= (WEA && WRITE_MODE_A == 0) ? DIA : w_rd_a;
    end

    // Port B first output stage, same rules as port A.
    always_ff @(posedge CLK) begin
        if (SSR) r_dob <= SRVAL_B;
        else if (ENB && (!WEB || WRITE_MODE_B != 2)) r_dob <= (WEB && WRITE_MODE_B == 0) ? DIB : w_rd_b;
    end

    // Optional output registers advance every cycle regardless of enables.
    always_ff @(posedge CLK) begin
        r_doa2 <= SSR ? SRVAL_A : r_doa;
        r_dob2 <= SSR ? SRVAL_B : r_dob;
    end

    // Collision pulse: both ports touch common bits and at least one writes.
    always_ff @(posedge CLK) begin
        r_coll <= !SSR && ENA && ENB && w_ovl && (WEA || WEB);
    end

    assign DOA  = (DO_REG_A != 0) ? r_doa2 : r_doa;
    assign DOB  = (DO_REG_B != 0) ? r_dob2 : r_dob;
    assign COLL = r_coll;
endmodule

// File: tb/tb_x_ramb_dp_sc.sv
// tb_x_ramb_dp_sc: directed self-checking bench across write modes and output-register options
module tb_x_ramb_dp_sc;
    logic        clk = 1'b0;
    logic        ssr, ena, wea, enb, web;
    logic [11:0] addra;
    logic [9:0]  addrb;
    logic [3:0]  dia;
    logic [15:0] dib;
    logic [3:0]  doa0, doa1, doa2, doa3;
    logic [15:0] dob0, dob1, dob2, dob3;
    logic        coll0, coll1, coll2, coll3;
    int          errors = 0;
    int          checks = 0;
    logic [3:0]  exp_s [8];

    always #5 clk = ~clk;

    x_ramb_dp_sc #(.SRVAL_A(4'h6), .SRVAL_B(16'h5A5A)) u_dut0 (
        .CLK(clk), .SSR(ssr), .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .DOA(doa0),
        .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .DOB(dob0), .COLL(coll0));
    x_ramb_dp_sc #(.WRITE_MODE_A(1), .WRITE_MODE_B(1)) u_dut1 (
        .CLK(clk), .SSR(ssr), .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .DOA(doa1),
        .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .DOB(dob1), .COLL(coll1));
    x_ramb_dp_sc #(.WRITE_MODE_A(2), .WRITE_MODE_B(2)) u_dut2 (
        .CLK(clk), .SSR(ssr), .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .DOA(doa2),
        .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .DOB(dob2), .COLL(coll2));
    x_ramb_dp_sc #(.DO_REG_A(1), .SRVAL_A(4'h9)) u_dut3 (
        .CLK(clk), .SSR(ssr), .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .DOA(doa3),
        .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .DOB(dob3), .COLL(coll3));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic ea, input logic wa, input logic [11:0] aa, input logic [3:0] da,
                       input logic eb, input logic wb, input logic [9:0] ab, input logic [15:0] db);
        ena = ea; wea = wa; addra = aa; dia = da;
        enb = eb; web = wb; addrb = ab; dib = db;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ssr = 1'b1;
        drv(1, 1, 12'd0, 4'hF, 0, 0, 10'd0, 16'h0);
        step();
        step();
        chk("rst_doa", doa0, 4'h6);
        chk("rst_dob", dob0, 16'h5A5A);
        chk("rst_coll", coll0, 1'b0);
        chk("rst_doa_pipe", doa3, 4'h9);
        ssr = 1'b0;
        drv(1, 0, 12'd0, 4'h0, 0, 0, 10'd0, 16'h0);
        step();
        chk("rst_blocked_write", doa0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            drv(1, 1, 12'(i), 4'(i + 1), 0, 0, 10'd0, 16'h0);
            step();
        end
        drv(0, 0, 12'd0, 4'h0, 1, 0, 10'd0, 16'h0);
        step();
        chk("narrow_to_wide", dob0, 16'h4321);
        drv(0, 0, 12'd0, 4'h0, 1, 1, 10'd1, 16'hABCD);
        step();
        chk("wb_wf", dob0, 16'hABCD);
        chk("wb_rf", dob1, 16'h0000);
        chk("wb_nc", dob2, 16'h4321);
        drv(1, 0, 12'd5, 4'h0, 0, 0, 10'd0, 16'h0);
        step();
        chk("wide_to_narrow", doa0, 4'hC);
        drv(0, 0, 12'd0, 4'h0, 1, 1, 10'd2, 16'h1111);
        step();
        drv(0, 0, 12'd0, 4'h0, 1, 0, 10'd1, 16'h0);
        step();
        drv(0, 0, 12'd0, 4'h0, 1, 1, 10'd2, 16'h2222);
        step();
        chk("modeb_write_first", dob0, 16'h2222);
        chk("modeb_read_first", dob1, 16'h1111);
        chk("modeb_no_change", dob2, 16'hABCD);
        drv(1, 1, 12'd12, 4'h1, 0, 0, 10'd0, 16'h0);
        step();
        drv(1, 0, 12'd5, 4'h0, 0, 0, 10'd0, 16'h0);
        step();
        drv(1, 1, 12'd12, 4'h2, 0, 0, 10'd0, 16'h0);
        step();
        chk("modea_write_first", doa0, 4'h2);
        chk("modea_read_first", doa1, 4'h1);
        chk("modea_no_change", doa2, 4'hC);
        drv(1, 0, 12'd4, 4'h0, 1, 1, 10'd0, 16'h0000);
        step();
        chk("no_overlap_coll", coll0, 1'b0);
        chk("no_overlap_doa", doa0, 4'hD);
        drv(1, 1, 12'd2, 4'h7, 1, 1, 10'd0, 16'h0000);
        step();
        chk("ww_coll", coll0, 1'b1);
        chk("ww_doa_own", doa0, 4'h7);
        drv(0, 0, 12'd0, 4'h0, 0, 0, 10'd0, 16'h0);
        step();
        chk("ww_coll_pulse", coll0, 1'b0);
        drv(0, 0, 12'd0, 4'h0, 1, 0, 10'd0, 16'h0);
        step();
        chk("ww_b_wins", dob0, 16'h0000);
        drv(0, 0, 12'd0, 4'h0, 1, 1, 10'd0, 16'h5555);
        step();
        drv(1, 0, 12'd1, 4'h0, 1, 1, 10'd0, 16'hAAAA);
        step();
        chk("rdw_old_data", doa0, 4'h5);
        chk("rdw_coll", coll0, 1'b1);
        drv(1, 0, 12'd1, 4'h0, 0, 0, 10'd0, 16'h0);
        step();
        chk("rdw_new_data", doa0, 4'hA);
        drv(1, 0, 12'd2, 4'h0, 1, 0, 10'd0, 16'h0);
        step();
        chk("rr_coll", coll0, 1'b0);
        chk("rr_dob", dob0, 16'hAAAA);
        chk("rr_doa", doa0, 4'hA);
        drv(0, 0, 12'd0, 4'h0, 1, 1, 10'd0, 16'h3210);
        step();
        exp_s = '{4'h0, 4'h1, 4'h2, 4'h3, 4'hD, 4'hC, 4'hB, 4'hA};
        for (int i = 0; i < 8; i++) begin
            drv(1, 0, 12'(i), 4'h0, 0, 0, 10'd0, 16'h0);
            ssr = (i == 4);
            step();
            if (i >= 1 && i <= 3) chk($sformatf("pipe_lag%0d", i), doa3, exp_s[i - 1]);
            if (i == 4) begin
                chk("pipe_flush", doa3, 4'h9);
                chk("mid_rst_doa", doa0, 4'h6);
                chk("mid_rst_dob", dob0, 16'h5A5A);
            end
            if (i == 5) chk("pipe_flush_stage2", doa3, 4'h9);
            if (i >= 6) chk($sformatf("pipe_resume%0d", i), doa3, exp_s[i - 1]);
        end
        ssr = 1'b0;
        drv(0, 0, 12'd0, 4'h0, 0, 0, 10'd0, 16'h0);
        step();
        chk("pipe_tail", doa3, exp_s[7]);
        step();
        chk("pipe_hold", doa3, exp_s[7]);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
